// File: rtl/reg_writeback_queue_if.sv
// Signal bundle for the register-file writeback queue: result intake, RF write port,
// and the rs1/rs2 read/forwarding path.
interface reg_writeback_queue_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rf_rs1_data;
  logic [DATA_W-1:0] rf_rs2_data;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport master (
    output flush, in_valid, in_addr, in_data, drain_en,
           rs1_addr, rs2_addr, rf_rs1_data, rf_rs2_data,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           rs1_data, rs2_data, count, empty, full
  );

  modport slave (
    input  flush, in_valid, in_addr, in_data, drain_en,
           rs1_addr, rs2_addr, rf_rs1_data, rf_rs2_data,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           rs1_data, rs2_data, count, empty, full
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO: buffers results, drains one per cycle to the register file,
// and forwards the youngest pending value for each read port.
module reg_writeback_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_writeback_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rs1;
  logic [DATA_W-1:0] w_rs2;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_ready = !w_full && !bus.flush && !reset;
  assign w_push  = bus.in_valid && w_ready;
  // Reset also masks the write so a squashed queue never reaches the register file.
  assign w_pop   = !w_empty && bus.drain_en && !bus.flush && !reset;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= bus.in_addr;
        r_data[r_tail] <= bus.in_data;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_rs1 = bus.rf_rs1_data;
    w_rs2 = bus.rf_rs2_data;
    w_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if (r_addr[w_idx] == bus.rs1_addr) w_rs1 = r_data[w_idx];
        if (r_addr[w_idx] == bus.rs2_addr) w_rs2 = r_data[w_idx];
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.rf_wr_en   = w_pop;
  assign bus.rf_wr_addr = r_addr[r_head];
  assign bus.rf_wr_data = r_data[r_head];
  assign bus.rs1_data   = w_rs1;
  assign bus.rs2_data   = w_rs2;
  assign bus.count      = r_count;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
endmodule
